// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: owns the sequential fetch pointer, issues
// one-cycle-latency reads to instruction memory, and buffers returned words
// in a first-word-fall-through queue drained by decode. A redirect flushes
// everything and restarts fetch; a HLT entering the queue stops fetching.
module instr_prefetch_queue #(
   parameter int         DEPTH  = 4,
   parameter int         AW     = 16,
   parameter logic [3:0] HLT_OP = 4'hF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     imem_req,
   output logic [AW-1:0]            imem_addr,
   input  logic [15:0]              imem_rdata,
   input  logic                     imem_rvalid,
   input  logic                     redirect,
   input  logic [AW-1:0]            redirect_addr,
   output logic [15:0]              inst,
   output logic [AW-1:0]            inst_pc,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic                     halted,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int              PW      = $clog2(DEPTH);
   localparam int              CW      = PW + 1;
   localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

   // Control state
   logic [AW-1:0] fetch_ptr_reg;
   logic [AW-1:0] req_addr_reg;
   logic          inflight_reg;
   logic          drop_reg;
   logic          halted_reg;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [15:0]   hold_inst_reg;
   logic [AW-1:0] hold_pc_reg;

   // Queue storage: instruction word in the upper bits, its address below
   logic [16+AW-1:0] entry_mem [DEPTH];

   logic [CW:0]      credit_sum;
   logic             issue;
   logic             not_empty;
   logic             enq;
   logic             deq;
   logic             enq_hlt;
   logic [16+AW-1:0] head;

   // Credit check counts the in-flight word so a response always has a slot
   assign credit_sum = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
   assign issue      = rst_n & ~halted_reg & ~redirect & (credit_sum < DEPTH_W);
   assign not_empty  = (count_reg != '0);
   // A redirect voids any enqueue or dequeue in the same cycle
   assign enq        = imem_rvalid & ~drop_reg & ~redirect;
   assign deq        = not_empty & inst_ready & ~redirect;
   assign enq_hlt    = enq & (imem_rdata[15:12] == HLT_OP);
   assign head       = entry_mem[rd_ptr_reg];

   assign imem_req   = issue;
   assign imem_addr  = fetch_ptr_reg;
   assign inst_valid = not_empty;
   assign halted     = halted_reg;
   assign count      = count_reg;
   // Head shows through while non-empty; otherwise the last shown value holds
   assign inst       = not_empty ? head[16+AW-1:AW] : hold_inst_reg;
   assign inst_pc    = not_empty ? head[AW-1:0]     : hold_pc_reg;

   // Next occupancy from simultaneous push/pop
   always_comb begin
      count_next = count_reg;
      case ({enq, deq})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   // Fetch pointer, request tracking, halt/drop flags and queue pointers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_ptr_reg <= '0;
         req_addr_reg  <= '0;
         inflight_reg  <= 1'b0;
         drop_reg      <= 1'b0;
         halted_reg    <= 1'b0;
         count_reg     <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         hold_inst_reg <= '0;
         hold_pc_reg   <= '0;
      end else begin
         if (not_empty) begin
            hold_inst_reg <= head[16+AW-1:AW];
            hold_pc_reg   <= head[AW-1:0];
         end
         if (redirect) begin
            fetch_ptr_reg <= redirect_addr;
            inflight_reg  <= 1'b0;
            drop_reg      <= inflight_reg;
            halted_reg    <= 1'b0;
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
         end else begin
            if (issue) begin
               fetch_ptr_reg <= fetch_ptr_reg + AW'(1);
               req_addr_reg  <= fetch_ptr_reg;
            end
            inflight_reg <= issue;
            // The response already requested behind a HLT must be discarded
            drop_reg     <= enq_hlt;
            if (enq_hlt)
               halted_reg <= 1'b1;
            if (enq)
               wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (deq)
               rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
         end
      end
   end

   // Queue storage write; contents need no reset
   always_ff @(posedge clk) begin
      if (enq)
         entry_mem[wr_ptr_reg] <= {imem_rdata, req_addr_reg};
   end

   // Credit scheme must never let a response arrive into a full queue
   always_ff @(posedge clk) begin
      if (rst_n && enq)
         no_overflow: assert (count_reg < DEPTH_C);
   end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Fetch front-end between the program-counter stage and decode.
- Owns the sequential fetch pointer and issues one-cycle-latency reads to instruction memory.
- Buffers up to DEPTH instructions in a first-word-fall-through queue that decode drains with a valid/ready handshake.
- Handles branch redirects (flush) and stops fetching after a HLT instruction enters the queue.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- AW, 16, instruction address width.
- HLT_OP, 4'hF, opcode value in inst[15:12] that marks HLT.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- imem_req  output  1  read request to instruction memory this cycle
- imem_addr  output  AW  read address, valid when imem_req=1
- imem_rdata  input  16  read data
- imem_rvalid  input  1  rdata valid; high exactly one cycle after each imem_req
- redirect  input  1  flush queue and restart fetch at redirect_addr
- redirect_addr  input  AW  new fetch address
- inst  output  16  head-of-queue instruction
- inst_pc  output  AW  address of inst
- inst_valid  output  1  queue non-empty
- inst_ready  input  1  decode accepts head this cycle
- halted  output  1  HLT enqueued; fetching stopped
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: all state is cleared on a rising clk edge with rst_n=0.
  - fetch_ptr=0, occupancy=0, inflight=0, drop=0, halted=0.
  - inst_valid=0, imem_req=0, inst=0, inst_pc=0, count=0.
- Issue rule: imem_req = rst_n & !halted & !redirect & (count + inflight < DEPTH).
  - Combinational from registered state plus redirect.
  - imem_addr = fetch_ptr.
- On issue: fetch_ptr <= fetch_ptr+1, modulo 2^AW (0xFFFF wraps to 0x0000); inflight <= 1.
- Without issue, inflight <= 0. At most one request is outstanding; back-to-back issue is allowed every cycle.
- Response: imem_rvalid=1 with drop=0 enqueues {imem_rdata, address of that request} at the tail.
  - The request address is held in a one-entry register.
  - imem_rvalid=1 with drop=1 is discarded.
- Latency: request in cycle N, enqueue at end of N+1, inst_valid=1 in N+2. This is the first-instruction latency out of reset and after redirect.
- Dequeue: inst_valid & inst_ready pops the head at the clock edge.
  - inst and inst_pc show the head combinationally (FWFT).
  - When empty, inst and inst_pc hold their last values.
- Occupancy updates:
  - Enqueue and dequeue in the same cycle: count unchanged.
  - Credit rule guarantees no enqueue while full; overflow is impossible and is asserted in simulation.
  - Dequeue when empty is ignored.
- Halt:
  - When the enqueued instruction has inst[15:12]==HLT_OP, halted <= 1.
  - The response arriving in the following cycle (already requested) is dropped via drop <= 1.
  - No further requests issue while halted.
  - The queue continues to drain normally; HLT itself is delivered to decode.
- Redirect (redirect=1 at a clock edge):
  - Queue emptied (count <= 0) and fetch_ptr <= redirect_addr.
  - halted <= 0.
  - drop <= inflight, so a response due next cycle is discarded.
  - No request is issued in the redirect cycle.
  - Redirect dominates: any enqueue or dequeue in the same cycle is void; decode must ignore that cycle's handshake.
  - First request to redirect_addr issues in the cycle after redirect.
- drop clears to 0 in any cycle it is not set.
- Reset asserted mid-operation: identical to power-up reset; pending responses are discarded because inflight and drop clear and any rvalid during reset is ignored.
- Queue storage needs no reset. Pointers wrap modulo DEPTH.

Test Plan:
- Reset release, memory returns mem[a]=0x1000+a, inst_ready=1 → first imem_req at addr 0 in cycle 1; inst_valid in cycle 3 with inst=0x1000, inst_pc=0; then one instruction per cycle with pc 1,2,3...
- inst_ready=0 for 10 cycles → exactly DEPTH=4 requests (addr 0..3); count=4; imem_req=0 until a pop; after one pop, next request is addr 4.
- mem[5]=0xF000 (HLT), ready=1 → halted=1 after addr 5 enqueued; addr 6 response dropped; decode receives pc 0..5 only; queue empties and imem_req stays 0.
- With queue holding 3 entries and one in flight, redirect=1 with redirect_addr=0x0040 → count=0 next cycle; in-flight data not enqueued; next request addr 0x0040; first inst_pc=0x0040.
- redirect_addr=0xFFFE → successive inst_pc 0xFFFE, 0xFFFF, 0x0000.
- rst_n=0 for one cycle while count=2 and a request in flight → count=0, inst_valid=0, halted=0; after release, fetch restarts at addr 0 with no stale data delivered.
